// File: rtl/seg_pkg.sv
// seg_pkg: shared segment patterns, slot phase type and index width for the scan display
package seg_pkg;
  localparam int IDX_W = 2;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;
  typedef enum logic {GAP, SHOW} slot_t;
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: BCD digit to active-high {g,f,e,d,c,b,a}; non-BCD codes show a dash
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: 4-digit multiplexed seven-segment driver with frame snapshot, ghost gap and zero blanking
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int GHOST_GAP   = 4,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_en,
  input  logic       blank_lz,
  input  logic [3:0] dig3,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic SP = SEG_ACT_LOW != 0;
  localparam logic AP = AN_ACT_LOW != 0;
  logic [DW-1:0]    div_cnt;
  logic [IDX_W-1:0] idx;
  logic [15:0]      shadow;
  logic [3:0]       cur, an_nx;
  logic [6:0]       dec_seg, seg_nx;
  logic             slot_end, bl3, bl2, bl1, blank, on;
  slot_t            slot;
  assign slot_end = div_cnt == DW'(SCAN_DIV - 1);
  seg_decoder u_dec (.bcd(cur), .seg(dec_seg));
  // blanking chains from the left so a non-zero or dash digit stops it for everything to its right
  always_comb begin
    slot   = int'(div_cnt) < GHOST_GAP ? GAP : SHOW;
    cur    = shadow[{idx, 2'b00} +: 4];
    bl3    = blank_lz && shadow[15:12] == 4'd0;
    bl2    = bl3 && shadow[11:8] == 4'd0;
    bl1    = bl2 && shadow[7:4] == 4'd0;
    blank  = idx == 2'd3 ? bl3 : idx == 2'd2 ? bl2 : idx == 2'd1 ? bl1 : 1'b0;
    on     = disp_en && slot == SHOW;
    an_nx  = on ? 4'b0001 << idx : 4'b0000;
    seg_nx = on && !blank ? dec_seg : SEG_OFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      shadow  <= '0;
      seg     <= {7{SP}};
      dp      <= SP;
      an      <= {4{AP}};
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) idx <= idx + 1'b1;
      if (slot_end && &idx) shadow <= {dig3, dig2, dig1, dig0};
      seg     <= seg_nx ^ {7{SP}};
      dp      <= SP;
      an      <= an_nx ^ {4{AP}};
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed table plus hand sequences for the scan display (SCAN_DIV=8, GHOST_GAP=2, active-high outputs)
module tb_seg_scan_display;
  logic       clk = 0, rst = 1, disp_en = 1, blank_lz = 0;
  logic [3:0] dig3 = 0, dig2 = 0, dig1 = 0, dig0 = 0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  int tests = 0, fails = 0, cyc = -1;

  seg_scan_display #(.SCAN_DIV(8), .GHOST_GAP(2), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) dut (
    .clk(clk), .rst(rst), .disp_en(disp_en), .blank_lz(blank_lz),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] dig;
    logic        blz;
    int          slot;
    int          off;
    logic [6:0]  eseg;
    logic [3:0]  ean;
  } vec_t;
  vec_t v[17];

  task automatic set_dig(input logic [15:0] d);
    {dig3, dig2, dig1, dig0} = d;
  endtask

  task automatic at(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [6:0] es, input logic [3:0] ea);
    tests++;
    if (seg !== es || an !== ea || dp !== 1'b0) begin
      fails++;
      $display("FAIL %s: got seg=%h an=%b dp=%b, expected seg=%h an=%b dp=0 (cyc=%0d)", nm, seg, an, dp, es, ea, cyc);
    end
  endtask

  initial begin
    v[0]  = '{16'h1529, 0, 0, 2, 7'h6F, 4'b0001};
    v[1]  = '{16'h1529, 0, 1, 5, 7'h5B, 4'b0010};
    v[2]  = '{16'h1529, 0, 2, 7, 7'h6D, 4'b0100};
    v[3]  = '{16'h1529, 0, 3, 3, 7'h06, 4'b1000};
    v[4]  = '{16'h1529, 0, 2, 0, 7'h00, 4'b0000};
    v[5]  = '{16'h1529, 0, 3, 1, 7'h00, 4'b0000};
    v[6]  = '{16'h0007, 1, 3, 4, 7'h00, 4'b1000};
    v[7]  = '{16'h0007, 1, 2, 4, 7'h00, 4'b0100};
    v[8]  = '{16'h0007, 1, 1, 4, 7'h00, 4'b0010};
    v[9]  = '{16'h0007, 1, 0, 4, 7'h07, 4'b0001};
    v[10] = '{16'h0000, 1, 0, 3, 7'h3F, 4'b0001};
    v[11] = '{16'h0000, 1, 1, 3, 7'h00, 4'b0010};
    v[12] = '{16'h000C, 0, 0, 6, 7'h40, 4'b0001};
    v[13] = '{16'h00C0, 1, 1, 6, 7'h40, 4'b0010};
    v[14] = '{16'h00C0, 1, 0, 6, 7'h3F, 4'b0001};
    v[15] = '{16'h0007, 0, 3, 2, 7'h3F, 4'b1000};
    v[16] = '{16'h0800, 1, 2, 4, 7'h7F, 4'b0100};

    repeat (3) @(negedge clk);
    chk("reset_hold", 7'h00, 4'b0000);
    rst = 0;
    at(0); chk("slot0_gap0", 7'h00, 4'b0000);
    at(1); chk("slot0_gap1", 7'h00, 4'b0000);
    at(2); chk("first_frame_0000", 7'h3F, 4'b0001);

    for (int i = 0; i < 17; i++) begin
      set_dig(v[i].dig);
      blank_lz = v[i].blz;
      at(32 * (2 * i + 2) + 8 * v[i].slot + v[i].off);
      chk($sformatf("vec%0d", i), v[i].eseg, v[i].ean);
    end

    blank_lz = 0;
    set_dig(16'h0010);
    at(32 * 37 + 3);  set_dig(16'h0030);
    at(32 * 37 + 12); chk("midframe_old", 7'h06, 4'b0010);
    at(32 * 38 + 12); chk("midframe_new", 7'h4F, 4'b0010);
    at(32 * 38 + 30); set_dig(16'h0050);
    at(32 * 39 + 12); chk("snap_edge_capture", 7'h6D, 4'b0010);

    at(32 * 41 + 11); disp_en = 0;
    at(32 * 41 + 12); chk("disp_off_next", 7'h00, 4'b0000);
    at(32 * 41 + 21); chk("disp_off_held", 7'h00, 4'b0000);
    disp_en = 1;
    at(32 * 41 + 22); chk("disp_resume_slot2", 7'h3F, 4'b0100);

    set_dig(16'h1529);
    at(32 * 43 + 12); chk("pre_rst_slot1", 7'h5B, 4'b0010);
    at(32 * 43 + 19); rst = 1;
    @(posedge clk); @(negedge clk);
    chk("rst_midslot", 7'h00, 4'b0000);
    rst = 0;
    at(1);  chk("rst_restart_gap", 7'h00, 4'b0000);
    at(2);  chk("rst_restart_slot0", 7'h3F, 4'b0001);
    at(10); chk("rst_shadow_cleared", 7'h3F, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
